// File: rtl/math_sched_pkg.sv
// Shared types and constants for the math_core request scheduler.
package math_sched_pkg;

    localparam int DATA_W   = 32;
    // Wide enough for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        QUIESCED
    } sched_state_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/math_core_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter
    import math_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    id
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < unsigned'(NUM_REQ); i++) begin
            idx = (unsigned'(32'(ptr)) + i) % unsigned'(NUM_REQ);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                id         = ID_W'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/math_core_sched.sv
// Shares one math_core between NUM_REQ requesters with round-robin issue,
// ID tracking through the core latency, and a quiesce/drain handshake.
module math_core_sched
    import math_sched_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int CORE_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_ain,
    input  logic [NUM_REQ*DATA_W-1:0] req_bin,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_result,
    output logic [DATA_W-1:0]         core_ain,
    output logic [DATA_W-1:0]         core_bin,
    input  logic [DATA_W-1:0]         core_result,
    input  logic [DATA_W-1:0]         core_statistic,
    input  logic                      quiesce_req,
    output logic                      quiesce_ack,
    output logic [DATA_W-1:0]         stat_snapshot
);

    localparam int ID_W = id_width(NUM_REQ);

    sched_state_e        state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_id;
    logic                arb_en;
    logic                pipe_busy;
    logic [DATA_W-1:0]   core_ain_q, core_ain_d;
    logic [DATA_W-1:0]   core_bin_q, core_bin_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic [DATA_W-1:0]   stat_snapshot_q, stat_snapshot_d;
    // Stage 0 shadows the core_ain register; stages 1..CORE_LAT track the core itself.
    tag_t                tag_q [CORE_LAT+1];
    tag_t                tag_d [CORE_LAT+1];

    assign arb_en = (state_q == RUN) && !quiesce_req;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .enable (arb_en),
        .grant  (gnt),
        .id     (gnt_id)
    );

    always_comb begin
        pipe_busy = 1'b0;
        for (int unsigned k = 0; k <= unsigned'(CORE_LAT); k++) begin
            pipe_busy = pipe_busy | tag_q[k].valid;
        end
    end

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        core_ain_d      = '0;
        core_bin_d      = '0;
        rsp_valid_d     = '0;
        rsp_result_d    = rsp_result_q;
        stat_snapshot_d = stat_snapshot_q;
        tag_d[0]        = '0;
        for (int unsigned k = 1; k <= unsigned'(CORE_LAT); k++) begin
            tag_d[k] = tag_q[k-1];
        end

        if (|gnt) begin
            core_ain_d     = req_ain[gnt_id*DATA_W +: DATA_W];
            core_bin_d     = req_bin[gnt_id*DATA_W +: DATA_W];
            tag_d[0].valid = 1'b1;
            tag_d[0].id    = TAG_ID_W'(gnt_id);
            ptr_d          = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
        end

        if (tag_q[CORE_LAT].valid) begin
            rsp_result_d = core_result;
            for (int unsigned i = 0; i < unsigned'(NUM_REQ); i++) begin
                if (tag_q[CORE_LAT].id == TAG_ID_W'(i)) begin
                    rsp_valid_d[i] = 1'b1;
                end
            end
        end

        case (state_q)
            RUN:      if (quiesce_req) state_d = DRAIN;
            DRAIN: begin
                if (!quiesce_req)    state_d = RUN;
                else if (!pipe_busy) state_d = QUIESCED;
            end
            QUIESCED: if (!quiesce_req) state_d = RUN;
            default:  state_d = RUN;
        endcase

        if (state_d == QUIESCED && state_q != QUIESCED) begin
            stat_snapshot_d = core_statistic;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RUN;
            ptr_q           <= '0;
            core_ain_q      <= '0;
            core_bin_q      <= '0;
            rsp_valid_q     <= '0;
            rsp_result_q    <= '0;
            stat_snapshot_q <= '0;
            for (int unsigned k = 0; k <= unsigned'(CORE_LAT); k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            core_ain_q      <= core_ain_d;
            core_bin_q      <= core_bin_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_result_q    <= rsp_result_d;
            stat_snapshot_q <= stat_snapshot_d;
            for (int unsigned k = 0; k <= unsigned'(CORE_LAT); k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign req_ready     = gnt;
    assign core_ain      = core_ain_q;
    assign core_bin      = core_bin_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_result    = rsp_result_q;
    assign stat_snapshot = stat_snapshot_q;
    // Ack drops combinationally with quiesce_req, in the same cycle the FSM heads back to RUN.
    assign quiesce_ack   = (state_q == QUIESCED) && quiesce_req;

endmodule

// File: tb/tb_math_core_sched.sv
// Directed bench for math_core_sched with a behavioural adder standing in for math_core.
module tb_math_core_sched;

    localparam int NUM_REQ  = 4;
    localparam int CORE_LAT = 1;
    localparam int DW       = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*DW-1:0]  req_ain;
    logic [NUM_REQ*DW-1:0]  req_bin;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [DW-1:0]          rsp_result;
    logic [DW-1:0]          core_ain;
    logic [DW-1:0]          core_bin;
    logic [DW-1:0]          core_result;
    logic [DW-1:0]          core_statistic;
    logic                   quiesce_req;
    logic                   quiesce_ack;
    logic [DW-1:0]          stat_snapshot;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [NUM_REQ-1:0] log_v [$];
    logic [DW-1:0]      log_r [$];
    int                 log_c [$];
    logic               ack_seen = 1'b0;

    math_core_sched #(
        .NUM_REQ  (NUM_REQ),
        .CORE_LAT (CORE_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_ain        (req_ain),
        .req_bin        (req_bin),
        .rsp_valid      (rsp_valid),
        .rsp_result     (rsp_result),
        .core_ain       (core_ain),
        .core_bin       (core_bin),
        .core_result    (core_result),
        .core_statistic (core_statistic),
        .quiesce_req    (quiesce_req),
        .quiesce_ack    (quiesce_ack),
        .stat_snapshot  (stat_snapshot)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Adder core model: CORE_LAT register stages after sampling core_ain/core_bin.
    logic [DW-1:0] core_pipe [CORE_LAT];
    always @(posedge clk) begin
        core_pipe[0] <= core_ain + core_bin;
        for (int k = 1; k < CORE_LAT; k++) core_pipe[k] <= core_pipe[k-1];
    end
    assign core_result = core_pipe[CORE_LAT-1];

    always @(negedge clk) begin
        if (rsp_valid !== '0) begin
            log_v.push_back(rsp_valid);
            log_r.push_back(rsp_result);
            log_c.push_back(cyc);
        end
        if (quiesce_ack === 1'b1) ack_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_v.delete();
        log_r.delete();
        log_c.delete();
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_ain[i*DW +: DW] = a;
        req_bin[i*DW +: DW] = b;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; quiesce_req = 1'b0;
        req_ain = '0; req_bin = '0; core_statistic = 32'h1111_2222;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
        checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL reset_rsp_result: got %0h expected 0", rsp_result); end
        checks++; if (core_ain !== 32'd0 || core_bin !== 32'd0) begin errors++; $display("FAIL reset_core_ops: got %0h/%0h expected 0/0", core_ain, core_bin); end
        checks++; if (quiesce_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", quiesce_ack); end
        checks++; if (stat_snapshot !== 32'd0) begin errors++; $display("FAIL reset_snapshot: got %0h expected 0", stat_snapshot); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_idle: got %b expected 0000", req_ready); end
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_pointer: got %b expected 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_rdy;
        int t_first = 0;
        clear_log();
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'(c*256 + i), 32'd1000);
            req_valid = 4'b1111;
            #1;
            exp_rdy = 4'b0001 << (c % 4);
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, req_ready, exp_rdy); end
            tick();
            if (c == 0) t_first = cyc;
        end
        req_valid = '0;
        repeat (CORE_LAT + 3) tick();
        checks++;
        if (log_v.size() != 8) begin
            errors++; $display("FAIL rr_count: got %0d expected 8", log_v.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                exp_rdy = 4'b0001 << (k % 4);
                checks++; if (log_v[k] !== exp_rdy) begin errors++; $display("FAIL rr_rsp_id[%0d]: got %b expected %b", k, log_v[k], exp_rdy); end
                checks++; if (log_r[k] !== 32'(k*256 + (k % 4) + 1000)) begin errors++; $display("FAIL rr_rsp_data[%0d]: got %0d expected %0d", k, log_r[k], k*256 + (k % 4) + 1000); end
                checks++; if (log_c[k] != t_first + CORE_LAT + 1 + k) begin errors++; $display("FAIL rr_rsp_cycle[%0d]: got %0d expected %0d", k, log_c[k], t_first + CORE_LAT + 1 + k); end
            end
        end
    endtask

    task automatic test_single();
        int t0;
        clear_log();
        set_op(2, 32'd5, 32'd7);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", req_ready); end
        tick();
        t0 = cyc;
        req_valid = '0;
        checks++; if (core_ain !== 32'd5 || core_bin !== 32'd7) begin errors++; $display("FAIL single_core_ops: got %0d/%0d expected 5/7", core_ain, core_bin); end
        for (int n = 0; n < 10 && log_v.size() == 0; n++) tick();
        checks++;
        if (log_v.size() != 1) begin
            errors++; $display("FAIL single_count: got %0d expected 1", log_v.size());
        end else begin
            checks++; if (log_v[0] !== 4'b0100) begin errors++; $display("FAIL single_rsp_id: got %b expected 0100", log_v[0]); end
            checks++; if (log_r[0] !== 32'd12) begin errors++; $display("FAIL single_rsp_data: got %0d expected 12", log_r[0]); end
            checks++; if (log_c[0] != t0 + CORE_LAT + 1) begin errors++; $display("FAIL single_latency: got %0d expected %0d", log_c[0] - t0, CORE_LAT + 1); end
        end
    endtask

    task automatic test_wrap();
        clear_log();
        set_op(3, 32'd3, 32'd4);
        set_op(0, 32'd10, 32'd20);
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_first: got %b expected 1000", req_ready); end
        tick();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_second: got %b expected 0001", req_ready); end
        tick();
        req_valid = '0;
        for (int n = 0; n < 10 && log_v.size() < 2; n++) tick();
        checks++;
        if (log_v.size() != 2) begin
            errors++; $display("FAIL wrap_count: got %0d expected 2", log_v.size());
        end else begin
            checks++; if (log_v[0] !== 4'b1000 || log_r[0] !== 32'd7) begin errors++; $display("FAIL wrap_rsp0: got %b/%0d expected 1000/7", log_v[0], log_r[0]); end
            checks++; if (log_v[1] !== 4'b0001 || log_r[1] !== 32'd30) begin errors++; $display("FAIL wrap_rsp1: got %b/%0d expected 0001/30", log_v[1], log_r[1]); end
        end
    endtask

    task automatic test_quiesce();
        int t0;
        int t_ack = -1;
        clear_log();
        core_statistic = 32'h5EED_0042;
        set_op(1, 32'd40, 32'd2);
        req_valid = 4'b0010;
        #1;
        tick();
        t0 = cyc;
        quiesce_req = 1'b1;
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL quiesce_no_grant_run: got %b expected 0000", req_ready); end
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL quiesce_no_grant[%0d]: got %b expected 0000", n, req_ready); end
            if (quiesce_ack === 1'b1) begin t_ack = cyc; break; end
        end
        checks++; if (t_ack != t0 + CORE_LAT + 2) begin errors++; $display("FAIL quiesce_ack_cycle: got %0d expected %0d", t_ack - t0, CORE_LAT + 2); end
        checks++;
        if (log_v.size() != 1) begin
            errors++; $display("FAIL quiesce_inflight_count: got %0d expected 1", log_v.size());
        end else begin
            checks++; if (log_v[0] !== 4'b0010 || log_r[0] !== 32'd42) begin errors++; $display("FAIL quiesce_inflight_rsp: got %b/%0d expected 0010/42", log_v[0], log_r[0]); end
        end
        checks++; if (stat_snapshot !== 32'h5EED_0042) begin errors++; $display("FAIL quiesce_snapshot: got %0h expected 5eed0042", stat_snapshot); end
        core_statistic = 32'h0BAD_0000;
        repeat (2) tick();
        checks++; if (stat_snapshot !== 32'h5EED_0042) begin errors++; $display("FAIL quiesce_snapshot_hold: got %0h expected 5eed0042", stat_snapshot); end
        checks++; if (quiesce_ack !== 1'b1 || req_ready !== 4'b0000 || core_ain !== 32'd0) begin errors++; $display("FAIL quiesce_hold: got ack=%b rdy=%b ain=%0h expected 1/0000/0", quiesce_ack, req_ready, core_ain); end
        quiesce_req = 1'b0;
        #1;
        checks++; if (quiesce_ack !== 1'b0) begin errors++; $display("FAIL quiesce_ack_drop: got %b expected 0", quiesce_ack); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL quiesce_exit_cycle_ready: got %b expected 0000", req_ready); end
        tick();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL quiesce_resume: got %b expected 0100", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_reset_midop();
        clear_log();
        set_op(0, 32'd9, 32'd9);
        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (rsp_valid !== 4'b0000 || rsp_result !== 32'd0) begin errors++; $display("FAIL rst_mid_rsp: got %b/%0h expected 0000/0", rsp_valid, rsp_result); end
        checks++; if (core_ain !== 32'd0 || core_bin !== 32'd0) begin errors++; $display("FAIL rst_mid_core: got %0h/%0h expected 0/0", core_ain, core_bin); end
        checks++; if (stat_snapshot !== 32'd0 || quiesce_ack !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL rst_mid_misc: got snap=%0h ack=%b rdy=%b expected 0/0/0000", stat_snapshot, quiesce_ack, req_ready); end
        repeat (CORE_LAT + 4) tick();
        checks++; if (log_v.size() != 0) begin errors++; $display("FAIL rst_mid_ghost_rsp: got %0d responses expected 0", log_v.size()); end
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_mid_pointer: got %b expected 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_quiesce_pulse();
        clear_log();
        ack_seen = 1'b0;
        set_op(0, 32'd11, 32'd22);
        set_op(1, 32'd100, 32'd1);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL pulse_first_grant: got %b expected 0001", req_ready); end
        tick();
        req_valid = 4'b0010;
        quiesce_req = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL pulse_req_cycle: got %b expected 0000", req_ready); end
        tick();
        quiesce_req = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL pulse_drain_blocks: got %b expected 0000", req_ready); end
        tick();
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL pulse_back_to_run: got %b expected 0010", req_ready); end
        tick();
        req_valid = '0;
        for (int n = 0; n < 10 && log_v.size() < 2; n++) tick();
        checks++;
        if (log_v.size() != 2) begin
            errors++; $display("FAIL pulse_count: got %0d expected 2", log_v.size());
        end else begin
            checks++; if (log_v[0] !== 4'b0001 || log_r[0] !== 32'd33) begin errors++; $display("FAIL pulse_rsp0: got %b/%0d expected 0001/33", log_v[0], log_r[0]); end
            checks++; if (log_v[1] !== 4'b0010 || log_r[1] !== 32'd101) begin errors++; $display("FAIL pulse_rsp1: got %b/%0d expected 0010/101", log_v[1], log_r[1]); end
        end
        checks++; if (ack_seen !== 1'b0) begin errors++; $display("FAIL pulse_no_ack: got %b expected 0", ack_seen); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_quiesce();
        test_reset_midop();
        test_quiesce_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
